// File: rtl/aria_pkg.sv
// +----------------------------------------------------------------------------+
// | aria_pkg                                                                   |
// | Mode codes, round counts and key-schedule rotation amounts for ARIA.       |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

package aria_pkg;

    localparam logic [1:0] c_aria_128 = 2'b00;
    localparam logic [1:0] c_aria_192 = 2'b01;
    localparam logic [1:0] c_aria_256 = 2'b10;
    localparam logic [1:0] c_aria_bad = 2'b11;

    localparam logic [4:0] c_n_128 = 5'd12;
    localparam logic [4:0] c_n_192 = 5'd14;
    localparam logic [4:0] c_n_256 = 5'd16;

    // Right-rotation amounts for key groups g0..g4
    localparam logic [6:0] c_rot_g0 = 7'd19;
    localparam logic [6:0] c_rot_g1 = 7'd31;
    localparam logic [6:0] c_rot_g2 = 7'd67;
    localparam logic [6:0] c_rot_g3 = 7'd97;
    localparam logic [6:0] c_rot_g4 = 7'd109;

    function automatic logic [4:0] rounds_for(input logic [1:0] mode);
        case (mode)
            c_aria_192: return c_n_192;
            c_aria_256: return c_n_256;
            default:    return c_n_128;
        endcase
    endfunction

    function automatic logic [127:0] rotr128(input logic [127:0] x, input logic [6:0] n);
        return (x >> n) | (x << (8'd128 - {1'b0, n}));
    endfunction

endpackage

`default_nettype wire

// File: rtl/aria_diffusion.sv
// +----------------------------------------------------------------------------+
// | aria_diffusion                                                             |
// | Combinational ARIA diffusion layer A (16x16 binary matrix, an involution). |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module aria_diffusion (
    input  logic [127:0] i_data,
    output logic [127:0] o_data
);

    logic [7:0] w_x [16];
    logic [7:0] w_y [16];

    // Byte 0 is the most significant byte
    for (genvar b = 0; b < 16; b++) begin : g_bytes
        assign w_x[b] = i_data[127-8*b -: 8];
        assign o_data[127-8*b -: 8] = w_y[b];
    end

    always_comb begin
        w_y[0]  = w_x[3]  ^ w_x[4]  ^ w_x[6]  ^ w_x[8]  ^ w_x[9]  ^ w_x[13] ^ w_x[14];
        w_y[1]  = w_x[2]  ^ w_x[5]  ^ w_x[7]  ^ w_x[8]  ^ w_x[9]  ^ w_x[12] ^ w_x[15];
        w_y[2]  = w_x[1]  ^ w_x[4]  ^ w_x[6]  ^ w_x[10] ^ w_x[11] ^ w_x[12] ^ w_x[15];
        w_y[3]  = w_x[0]  ^ w_x[5]  ^ w_x[7]  ^ w_x[10] ^ w_x[11] ^ w_x[13] ^ w_x[14];
        w_y[4]  = w_x[0]  ^ w_x[2]  ^ w_x[5]  ^ w_x[8]  ^ w_x[11] ^ w_x[14] ^ w_x[15];
        w_y[5]  = w_x[1]  ^ w_x[3]  ^ w_x[4]  ^ w_x[9]  ^ w_x[10] ^ w_x[14] ^ w_x[15];
        w_y[6]  = w_x[0]  ^ w_x[2]  ^ w_x[7]  ^ w_x[9]  ^ w_x[10] ^ w_x[12] ^ w_x[13];
        w_y[7]  = w_x[1]  ^ w_x[3]  ^ w_x[6]  ^ w_x[8]  ^ w_x[11] ^ w_x[12] ^ w_x[13];
        w_y[8]  = w_x[0]  ^ w_x[1]  ^ w_x[4]  ^ w_x[7]  ^ w_x[10] ^ w_x[13] ^ w_x[15];
        w_y[9]  = w_x[0]  ^ w_x[1]  ^ w_x[5]  ^ w_x[6]  ^ w_x[11] ^ w_x[12] ^ w_x[14];
        w_y[10] = w_x[2]  ^ w_x[3]  ^ w_x[5]  ^ w_x[6]  ^ w_x[8]  ^ w_x[13] ^ w_x[15];
        w_y[11] = w_x[2]  ^ w_x[3]  ^ w_x[4]  ^ w_x[7]  ^ w_x[9]  ^ w_x[12] ^ w_x[14];
        w_y[12] = w_x[1]  ^ w_x[2]  ^ w_x[6]  ^ w_x[7]  ^ w_x[9]  ^ w_x[11] ^ w_x[12];
        w_y[13] = w_x[0]  ^ w_x[3]  ^ w_x[6]  ^ w_x[7]  ^ w_x[8]  ^ w_x[10] ^ w_x[13];
        w_y[14] = w_x[0]  ^ w_x[3]  ^ w_x[4]  ^ w_x[5]  ^ w_x[9]  ^ w_x[11] ^ w_x[14];
        w_y[15] = w_x[1]  ^ w_x[2]  ^ w_x[4]  ^ w_x[5]  ^ w_x[8]  ^ w_x[10] ^ w_x[15];
    end

endmodule

`default_nettype wire

// File: rtl/aria_round_key_gen.sv
// +----------------------------------------------------------------------------+
// | aria_round_key_gen                                                         |
// | Emits ARIA encryption or decryption round keys, one per handshake.         |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module aria_round_key_gen
    import aria_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    output logic         start_ready,
    input  logic [1:0]   aria_mode,
    input  logic         dec,
    input  logic [127:0] w0,
    input  logic [127:0] w1,
    input  logic [127:0] w2,
    input  logic [127:0] w3,
    output logic [127:0] rkey,
    output logic         rkey_valid,
    input  logic         rkey_ready,
    output logic [4:0]   rkey_idx,
    output logic         rkey_last,
    output logic         mode_err
);

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_EMIT = 1'b1} state_t;

    state_t       r_state;
    state_t       w_state_nxt;
    logic [127:0] r_w0, r_w1, r_w2, r_w3;
    logic [4:0]   r_n;
    logic         r_dec;
    logic [4:0]   r_k;
    logic [127:0] r_rkey;
    logic         r_valid;
    logic [4:0]   r_idx;
    logic         r_last;
    logic         r_mode_err;

    logic         w_accept, w_load, w_done, w_use_a;
    logic [4:0]   w_i, w_im1;
    logic [6:0]   w_rot;
    logic [127:0] w_ek, w_ek_a, w_key;

    assign w_accept = (r_state == ST_IDLE) && start && (aria_mode != c_aria_bad);
    assign w_load   = (r_state == ST_EMIT) && (!r_valid || rkey_ready) && (r_k <= r_n);
    assign w_done   = (r_state == ST_EMIT) && r_valid && rkey_ready && r_last;

    // Decrypt walks the encryption schedule backwards
    always_comb begin
        w_i   = r_dec ? (r_n + 5'd1 - r_k) : (r_k + 5'd1);
        w_im1 = w_i - 5'd1;
        case (w_im1[4:2])
            3'd0:    w_rot = c_rot_g0;
            3'd1:    w_rot = c_rot_g1;
            3'd2:    w_rot = c_rot_g2;
            3'd3:    w_rot = c_rot_g3;
            default: w_rot = c_rot_g4;
        endcase
        case (w_im1[1:0])
            2'd0:    w_ek = r_w0 ^ rotr128(r_w1, w_rot);
            2'd1:    w_ek = r_w1 ^ rotr128(r_w2, w_rot);
            2'd2:    w_ek = r_w2 ^ rotr128(r_w3, w_rot);
            default: w_ek = rotr128(r_w0, w_rot) ^ r_w3;
        endcase
    end

    aria_diffusion u_diffusion (
        .i_data (w_ek),
        .o_data (w_ek_a)
    );

    // Decrypt endpoints are used unmodified
    assign w_use_a = r_dec && (r_k != 5'd0) && (r_k != r_n);
    assign w_key   = w_use_a ? w_ek_a : w_ek;

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_state_nxt = ST_EMIT;
            ST_EMIT: if (w_done)   w_state_nxt = ST_IDLE;
            default:               w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_w0       <= '0;
            r_w1       <= '0;
            r_w2       <= '0;
            r_w3       <= '0;
            r_n        <= '0;
            r_dec      <= 1'b0;
            r_k        <= '0;
            r_rkey     <= '0;
            r_valid    <= 1'b0;
            r_idx      <= '0;
            r_last     <= 1'b0;
            r_mode_err <= 1'b0;
        end else begin
            r_mode_err <= (r_state == ST_IDLE) && start && (aria_mode == c_aria_bad);
            if (w_accept) begin
                r_w0  <= w0;
                r_w1  <= w1;
                r_w2  <= w2;
                r_w3  <= w3;
                r_n   <= rounds_for(aria_mode);
                r_dec <= dec;
                r_k   <= '0;
            end else if (w_load) begin
                r_rkey  <= w_key;
                r_idx   <= r_k + 5'd1;
                r_last  <= (r_k == r_n);
                r_valid <= 1'b1;
                r_k     <= r_k + 5'd1;
            end else if (w_done) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign start_ready = (r_state == ST_IDLE);
    assign rkey        = r_rkey;
    assign rkey_valid  = r_valid;
    assign rkey_idx    = r_idx;
    assign rkey_last   = r_last;
    assign mode_err    = r_mode_err;

endmodule

`default_nettype wire

// File: tb/tb_aria_round_key_gen.sv
// +----------------------------------------------------------------------------+
// | tb_aria_round_key_gen                                                      |
// | Randomised self-checking bench against a behavioural key-schedule model.   |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_aria_round_key_gen;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         start_ready;
    logic [1:0]   aria_mode = 2'b00;
    logic         dec = 1'b0;
    logic [127:0] w0 = '0, w1 = '0, w2 = '0, w3 = '0;
    logic [127:0] rkey;
    logic         rkey_valid;
    logic         rkey_ready = 1'b1;
    logic [4:0]   rkey_idx;
    logic         rkey_last;
    logic         mode_err;

    int tests = 0;
    int fails = 0;

    logic [127:0] got_key [32];
    logic [4:0]   got_idx [32];
    logic         got_last [32];
    int           got_cyc [32];

    logic [127:0] cw0, cw1, cw2, cw3;
    int           cn;
    bit           cdec;

    localparam int ROT_R [5] = '{19, 31, 67, 97, 109};
    // Row r lists which input bytes feed output byte r (bit j = input byte j)
    localparam logic [15:0] A_MASK [16] = '{
        16'h6358, 16'h93A4, 16'h9C52, 16'h6CA1, 16'hC925, 16'hC61A, 16'h3685, 16'h394A,
        16'hA493, 16'h5863, 16'hA16C, 16'h529C, 16'h1AC6, 16'h25C9, 16'h4A39, 16'h8536};

    aria_round_key_gen dut (
        .clk(clk), .rst(rst), .start(start), .start_ready(start_ready),
        .aria_mode(aria_mode), .dec(dec), .w0(w0), .w1(w1), .w2(w2), .w3(w3),
        .rkey(rkey), .rkey_valid(rkey_valid), .rkey_ready(rkey_ready),
        .rkey_idx(rkey_idx), .rkey_last(rkey_last), .mode_err(mode_err));

    always #5 clk = ~clk;

    function automatic logic [127:0] m_rotr(input logic [127:0] x, input int n);
        logic [255:0] t;
        t = {x, x} >> n;
        return t[127:0];
    endfunction

    function automatic logic [127:0] m_ek(input int i);
        int g, p;
        g = (i - 1) / 4;
        p = (i - 1) % 4;
        case (p)
            0:       return cw0 ^ m_rotr(cw1, ROT_R[g]);
            1:       return cw1 ^ m_rotr(cw2, ROT_R[g]);
            2:       return cw2 ^ m_rotr(cw3, ROT_R[g]);
            default: return m_rotr(cw0, ROT_R[g]) ^ cw3;
        endcase
    endfunction

    function automatic logic [127:0] m_A(input logic [127:0] x);
        logic [127:0] y;
        logic [7:0]   yb;
        logic [15:0]  m;
        y = '0;
        for (int r = 0; r < 16; r++) begin
            yb = 8'h00;
            m  = A_MASK[r];
            for (int j = 0; j < 16; j++)
                if (m[j]) yb = yb ^ x[127-8*j -: 8];
            y[127-8*r -: 8] = yb;
        end
        return y;
    endfunction

    function automatic logic [127:0] m_key(input int k);
        if (!cdec) return m_ek(k + 1);
        if (k == 0 || k == cn) return m_ek(cn + 1 - k);
        return m_A(m_ek(cn + 1 - k));
    endfunction

    task automatic set_model(input logic [127:0] a, b, c, d, input logic [1:0] mode, input bit dd);
        cw0 = a; cw1 = b; cw2 = c; cw3 = d;
        cn = 12 + 2 * int'(mode);
        cdec = dd;
    endtask

    // Caller is #1 after a posedge with the DUT idle
    task automatic do_start(input logic [127:0] a, b, c, d, input logic [1:0] mode, input bit dd);
        w0 = a; w1 = b; w2 = c; w3 = d; aria_mode = mode; dec = dd; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        w0 = '0; w1 = '0; w2 = '0; w3 = '0;
    endtask

    // Collects handshaken keys until the last one; flags any output change during a stall
    task automatic capture(input bit rnd, output int n, output int viol, output bit tmo);
        logic [127:0] pk;
        logic [4:0]   pi;
        logic         pl;
        bit           pstall, r;
        n = 0; viol = 0; tmo = 1'b1; pstall = 1'b0;
        pk = '0; pi = '0; pl = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (pstall && (rkey !== pk || rkey_idx !== pi || rkey_last !== pl || rkey_valid !== 1'b1))
                viol++;
            r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            rkey_ready = r;
            if (rkey_valid && r) begin
                if (n < 32) begin
                    got_key[n] = rkey; got_idx[n] = rkey_idx; got_last[n] = rkey_last; got_cyc[n] = c;
                end
                n++;
            end
            pstall = rkey_valid && !r;
            pk = rkey; pi = rkey_idx; pl = rkey_last;
            @(posedge clk); #1;
            if (n > 0 && n <= 32 && got_last[n-1]) begin
                tmo = 1'b0;
                break;
            end
        end
        rkey_ready = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        tests++; if (start_ready !== 1'b1) begin fails++; $display("FAIL reset_start_ready got=%b exp=1", start_ready); end
        tests++; if (rkey_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got=%b exp=0", rkey_valid); end
        tests++; if (rkey !== 128'h0) begin fails++; $display("FAIL reset_rkey got=%h exp=0", rkey); end
        tests++; if (rkey_idx !== 5'd0) begin fails++; $display("FAIL reset_idx got=%0d exp=0", rkey_idx); end
        tests++; if (rkey_last !== 1'b0 || mode_err !== 1'b0) begin
            fails++; $display("FAIL reset_last_err got=%b%b exp=00", rkey_last, mode_err); end
    endtask

    task automatic test_enc128_unit;
        int n, viol;
        bit tmo;
        set_model(128'h1, '0, '0, '0, 2'b00, 1'b0);
        do_start(128'h1, '0, '0, '0, 2'b00, 1'b0);
        capture(1'b0, n, viol, tmo);
        tests++; if (tmo || n != 13) begin fails++; $display("FAIL enc128_count got=%0d exp=13 tmo=%b", n, tmo); end
        if (n == 13) begin
            for (int k = 0; k < 13; k++) begin
                tests++; if (got_key[k] !== m_key(k) || got_idx[k] !== 5'(k + 1) || got_last[k] !== (k == 12)) begin
                    fails++; $display("FAIL enc128_key k=%0d got=%h/%0d/%b exp=%h/%0d/%b", k,
                        got_key[k], got_idx[k], got_last[k], m_key(k), k + 1, k == 12); end
                tests++; if (got_cyc[k] != k + 1) begin
                    fails++; $display("FAIL enc128_timing k=%0d got=%0d exp=%0d", k, got_cyc[k], k + 1); end
            end
            tests++; if (got_key[0] !== 128'h1) begin fails++; $display("FAIL enc128_ek1 got=%h exp=1", got_key[0]); end
            tests++; if (got_key[3] !== 128'h0000_2000_0000_0000_0000_0000_0000_0000) begin
                fails++; $display("FAIL enc128_ek4 got=%h exp=2^109", got_key[3]); end
            tests++; if (got_key[12] !== 128'h1) begin fails++; $display("FAIL enc128_ek13 got=%h exp=1", got_key[12]); end
        end
        tests++; if (rkey_valid !== 1'b0 || start_ready !== 1'b1) begin
            fails++; $display("FAIL enc128_done got=%b%b exp=01", rkey_valid, start_ready); end
    endtask

    task automatic test_decrypt;
        logic [127:0] a, b, c, d;
        logic [127:0] enc [13];
        int n, viol;
        bit tmo;
        a = {$urandom, $urandom, $urandom, $urandom}; b = {$urandom, $urandom, $urandom, $urandom};
        c = {$urandom, $urandom, $urandom, $urandom}; d = {$urandom, $urandom, $urandom, $urandom};
        set_model(a, b, c, d, 2'b00, 1'b0);
        for (int k = 0; k < 13; k++) enc[k] = m_ek(k + 1);
        set_model(a, b, c, d, 2'b00, 1'b1);
        do_start(a, b, c, d, 2'b00, 1'b1);
        capture(1'b0, n, viol, tmo);
        tests++; if (tmo || n != 13) begin fails++; $display("FAIL dec_count got=%0d exp=13", n); end
        if (n == 13) begin
            tests++; if (got_key[0] !== enc[12]) begin fails++; $display("FAIL dec_dk1 got=%h exp=%h", got_key[0], enc[12]); end
            tests++; if (got_key[12] !== enc[0]) begin fails++; $display("FAIL dec_dk13 got=%h exp=%h", got_key[12], enc[0]); end
            tests++; if (got_key[1] !== m_A(enc[11])) begin fails++; $display("FAIL dec_dk2 got=%h exp=%h", got_key[1], m_A(enc[11])); end
            for (int k = 0; k < 13; k++) begin
                tests++; if (got_key[k] !== m_key(k) || got_idx[k] !== 5'(k + 1)) begin
                    fails++; $display("FAIL dec_key k=%0d got=%h/%0d exp=%h/%0d", k, got_key[k], got_idx[k], m_key(k), k + 1); end
            end
        end
    endtask

    task automatic test_modes_256_192;
        logic [127:0] a, b;
        int n, viol;
        bit tmo;
        a = {$urandom, $urandom, $urandom, $urandom}; b = {$urandom, $urandom, $urandom, $urandom};
        set_model(a, b, 128'h5, 128'h9, 2'b10, 1'b0);
        do_start(a, b, 128'h5, 128'h9, 2'b10, 1'b0);
        capture(1'b0, n, viol, tmo);
        tests++; if (tmo || n != 17) begin fails++; $display("FAIL m256_count got=%0d exp=17", n); end
        if (n == 17) begin
            tests++; if (got_key[16] !== (a ^ {b[108:0], b[127:109]}) || got_idx[16] !== 5'd17 || got_last[16] !== 1'b1) begin
                fails++; $display("FAIL m256_ek17 got=%h exp=%h", got_key[16], a ^ {b[108:0], b[127:109]}); end
            for (int k = 0; k < 17; k++) begin
                tests++; if (got_key[k] !== m_key(k)) begin fails++; $display("FAIL m256_key k=%0d got=%h exp=%h", k, got_key[k], m_key(k)); end
            end
        end
        set_model(b, a, 128'h7, 128'h3, 2'b01, 1'b0);
        do_start(b, a, 128'h7, 128'h3, 2'b01, 1'b0);
        capture(1'b0, n, viol, tmo);
        tests++; if (tmo || n != 15) begin fails++; $display("FAIL m192_count got=%0d exp=15", n); end
        if (n == 15) begin
            for (int k = 0; k < 15; k++) begin
                tests++; if (got_key[k] !== m_key(k) || got_last[k] !== (k == 14)) begin
                    fails++; $display("FAIL m192_key k=%0d got=%h/%b exp=%h/%b", k, got_key[k], got_last[k], m_key(k), k == 14); end
            end
        end
    endtask

    task automatic test_backpressure;
        logic [127:0] a, b, c, d;
        logic [1:0]   mode;
        bit           dd, tmo;
        int           n, viol;
        for (int it = 0; it < 4; it++) begin
            a = {$urandom, $urandom, $urandom, $urandom}; b = {$urandom, $urandom, $urandom, $urandom};
            c = {$urandom, $urandom, $urandom, $urandom}; d = {$urandom, $urandom, $urandom, $urandom};
            mode = 2'($urandom_range(0, 2));
            dd = 1'($urandom_range(0, 1));
            set_model(a, b, c, d, mode, dd);
            do_start(a, b, c, d, mode, dd);
            capture(1'b1, n, viol, tmo);
            tests++; if (tmo || n != cn + 1) begin fails++; $display("FAIL bp_count it=%0d got=%0d exp=%0d", it, n, cn + 1); end
            tests++; if (viol != 0) begin fails++; $display("FAIL bp_stall it=%0d got=%0d exp=0", it, viol); end
            if (n == cn + 1) begin
                for (int k = 0; k <= cn; k++) begin
                    tests++; if (got_key[k] !== m_key(k) || got_idx[k] !== 5'(k + 1) || got_last[k] !== (k == cn)) begin
                        fails++; $display("FAIL bp_key it=%0d k=%0d got=%h/%0d exp=%h/%0d", it, k, got_key[k], got_idx[k], m_key(k), k + 1); end
                end
            end
        end
    endtask

    task automatic test_mode_err_and_busy_start;
        int n, viol;
        bit tmo;
        aria_mode = 2'b11; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; aria_mode = 2'b00;
        tests++; if (mode_err !== 1'b1 || rkey_valid !== 1'b0 || start_ready !== 1'b1) begin
            fails++; $display("FAIL moderr_pulse got=%b%b%b exp=101", mode_err, rkey_valid, start_ready); end
        @(posedge clk); #1;
        tests++; if (mode_err !== 1'b0 || rkey_valid !== 1'b0) begin
            fails++; $display("FAIL moderr_clear got=%b%b exp=00", mode_err, rkey_valid); end
        set_model(128'hA5, 128'h3C, 128'hF0, 128'h0F, 2'b00, 1'b0);
        do_start(128'hA5, 128'h3C, 128'hF0, 128'h0F, 2'b00, 1'b0);
        rkey_ready = 1'b0;
        w0 = '1; w1 = '1; w2 = '1; w3 = '1; aria_mode = 2'b10; dec = 1'b1; start = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        tests++; if (start_ready !== 1'b0) begin fails++; $display("FAIL busy_ready got=%b exp=0", start_ready); end
        start = 1'b0;
        capture(1'b0, n, viol, tmo);
        tests++; if (tmo || n != 13) begin fails++; $display("FAIL busy_count got=%0d exp=13", n); end
        if (n == 13) begin
            for (int k = 0; k < 13; k++) begin
                tests++; if (got_key[k] !== m_key(k)) begin fails++; $display("FAIL busy_key k=%0d got=%h exp=%h", k, got_key[k], m_key(k)); end
            end
        end
    endtask

    task automatic test_reset_mid_run;
        int n, viol, hs;
        bit tmo;
        set_model(128'h11, 128'h22, 128'h33, 128'h44, 2'b00, 1'b0);
        do_start(128'h11, 128'h22, 128'h33, 128'h44, 2'b00, 1'b0);
        rkey_ready = 1'b1;
        hs = 0;
        for (int c = 0; c < 50 && hs < 5; c++) begin
            if (rkey_valid) hs++;
            @(posedge clk); #1;
        end
        tests++; if (hs != 5) begin fails++; $display("FAIL midrst_progress got=%0d exp=5", hs); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        tests++; if (rkey_valid !== 1'b0 || start_ready !== 1'b1 || rkey_idx !== 5'd0) begin
            fails++; $display("FAIL midrst_state got=%b%b/%0d exp=01/0", rkey_valid, start_ready, rkey_idx); end
        @(posedge clk); #1;
        tests++; if (rkey_valid !== 1'b0) begin fails++; $display("FAIL midrst_quiet got=%b exp=0", rkey_valid); end
        do_start(128'h11, 128'h22, 128'h33, 128'h44, 2'b00, 1'b0);
        capture(1'b0, n, viol, tmo);
        tests++; if (tmo || n != 13 || got_idx[0] !== 5'd1 || got_key[0] !== m_key(0)) begin
            fails++; $display("FAIL midrst_restart got=%0d/%0d exp=13/1", n, got_idx[0]); end
    endtask

    initial begin
        test_reset;
        test_enc128_unit;
        test_decrypt;
        test_modes_256_192;
        test_backpressure;
        test_mode_err_and_busy_start;
        test_reset_mid_run;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
